vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_change_gen.sv | 24 ++
 rtl/vend_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin denominations for the vending controller
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [2:0] COIN_1 = 3'd1;
  localparam logic [2:0] COIN_2 = 3'd2;
  localparam logic [2:0] COIN_5 = 3'd5;

  function automatic logic coin_legal(input logic [2:0] v);
    return (v == COIN_1) || (v == COIN_2) || (v == COIN_5);
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// rtl/vend_change_gen.sv - picks the largest change coin not exceeding the credit
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [2:0]          coin,
  output logic [CREDIT_W-1:0] remainder
);

  always_comb begin
    coin = 3'd0;
    if (credit >= CREDIT_W'(COIN_5)) begin
      coin = COIN_5;
    end else if (credit >= CREDIT_W'(COIN_2)) begin
      coin = COIN_2;
    end else if (credit != '0) begin
      coin = COIN_1;
    end
    remainder = credit - CREDIT_W'(coin);
  end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin-accepting vending controller with registered outputs
// Credit, vend and change are all updated on the edge that samples their cause.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 50
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        coin_valid,
  input  logic [2:0]                  coin_val,
  input  logic                        sel_valid,
  input  logic [$clog2(N_PROD)-1:0]   sel_id,
  input  logic                        cancel,
  input  logic [N_PROD*CREDIT_W-1:0]  prices,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        vend_valid,
  output logic [$clog2(N_PROD)-1:0]   vend_id,
  output logic                        change_valid,
  output logic [2:0]                  change_coin,
  output logic                        reject,
  output logic                        insuff,
  output logic                        busy
);

  localparam int SEL_W = $clog2(N_PROD);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic [2:0]          chg_coin;
  logic [CREDIT_W-1:0] chg_rem;
  logic                sel_ok, vend_ok, coin_ok, cancel_act;

  logic                vend_valid_d, change_valid_d, reject_d, insuff_d, busy_d;
  logic [SEL_W-1:0]    vend_id_d;
  logic [2:0]          change_coin_d;

  vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change (
    .credit    (credit),
    .coin      (chg_coin),
    .remainder (chg_rem)
  );

  // Loop lookup keeps out-of-range sel_id from indexing past the table.
  always_comb begin
    price = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (32'(sel_id) == 32'(i)) price = prices[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign sel_ok     = 32'(sel_id) < 32'(N_PROD);
  assign vend_ok    = sel_ok && (credit >= price);
  assign sum        = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
  assign coin_ok    = coin_legal(coin_val) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign cancel_act = cancel && (state_q == CREDIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_coin  <= 3'd0;
      reject       <= 1'b0;
      insuff       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit       <= credit_d;
      vend_valid   <= vend_valid_d;
      vend_id      <= vend_id_d;
      change_valid <= change_valid_d;
      change_coin  <= change_coin_d;
      reject       <= reject_d;
      insuff       <= insuff_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    case (state_q)
      IDLE, CREDIT: begin
        if (cancel_act) begin
          state_d = CHANGE;
        end else if (sel_valid) begin
          if (vend_ok) begin
            state_d  = VEND;
            credit_d = credit - price;
          end
        end else if (coin_valid && coin_ok) begin
          state_d  = CREDIT;
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      VEND:    state_d = (credit != '0) ? CHANGE : IDLE;
      CHANGE: begin
        credit_d = chg_rem;
        if (chg_rem == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vend_valid_d   = 1'b0;
    vend_id_d      = '0;
    change_valid_d = 1'b0;
    change_coin_d  = 3'd0;
    reject_d       = 1'b0;
    insuff_d       = 1'b0;
    busy_d         = (state_d == VEND) || (state_d == CHANGE);
    case (state_q)
      IDLE, CREDIT: begin
        if (cancel_act) begin
          reject_d = coin_valid;
        end else if (sel_valid) begin
          reject_d = coin_valid;
          if (vend_ok) begin
            vend_valid_d = 1'b1;
            vend_id_d    = sel_id;
          end else begin
            insuff_d = 1'b1;
          end
        end else begin
          reject_d = coin_valid && !coin_ok;
        end
      end
      VEND:    reject_d = coin_valid;
      CHANGE: begin
        reject_d       = coin_valid;
        change_valid_d = 1'b1;
        change_coin_d  = chg_coin;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl
module tb_vend_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        coin_valid, sel_valid, cancel;
  logic [2:0]  coin_val;
  logic [1:0]  sel_id;
  logic [31:0] prices;
  logic [7:0]  credit;
  logic        vend_valid, change_valid, reject, insuff, busy;
  logic [1:0]  vend_id;
  logic [2:0]  change_coin;

  int checks   = 0;
  int failures = 0;

  vend_ctrl #(.N_PROD(4), .CREDIT_W(8), .MAX_CREDIT(50)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .prices       (prices),
    .credit       (credit),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .reject       (reject),
    .insuff       (insuff),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [2:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    cyc();
    coin_valid = 1'b0;
    coin_val   = 3'd0;
  endtask

  task automatic sel(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    cyc();
    sel_valid = 1'b0;
    sel_id    = 2'd0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
  endtask

  // Collects change until busy drops; the last coin arrives with busy already low.
  task automatic drain(input string tag, input int exp_total);
    int total = 0;
    bit done  = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      cyc();
      if (change_valid) total += int'(change_coin);
      if (!busy) done = 1;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_total"}, total, exp_total);
    chk({tag, "_credit"}, credit, 0);
  endtask

  initial begin
    RST = 1'b1; coin_valid = 0; coin_val = 0; sel_valid = 0; sel_id = 0; cancel = 0;
    prices = {8'd0, 8'd10, 8'd7, 8'd3};
    cyc(); cyc();
    chk("rst_credit", credit, 0);
    chk("rst_pulses", {vend_valid, change_valid, reject, insuff, busy}, 0);
    chk("rst_ids", {vend_id, change_coin}, 0);
    RST = 1'b0;
    cyc();
    chk("post_rst_quiet", {vend_valid, change_valid, reject, insuff, busy}, 0);

    // coin 5, coin 2, buy product 1 at price 7
    coin(3'd5);
    chk("t1_credit5", credit, 5);
    coin(3'd2);
    chk("t1_credit7", credit, 7);
    sel(2'd1);
    chk("t1_vend", vend_valid, 1);
    chk("t1_vend_id", vend_id, 1);
    chk("t1_credit0", credit, 0);
    chk("t1_busy_vend", busy, 1);
    cyc();
    chk("t1_after", {vend_valid, change_valid, busy}, 0);
    cyc();
    chk("t1_no_change", change_valid, 0);

    // 10 in, product 0 at 3 -> change 5 then 2; coin in VEND rejected
    coin(3'd5); coin(3'd5);
    chk("t2_credit10", credit, 10);
    sel(2'd0);
    chk("t2_vend", {vend_valid, 2'(vend_id)}, 3'b100);
    chk("t2_credit7", credit, 7);
    coin(3'd1);
    chk("t2_vend_reject", reject, 1);
    chk("t2_vend_credit", credit, 7);
    chk("t2_busy", busy, 1);
    cyc();
    chk("t2_chg5", {change_valid, change_coin}, {1'b1, 3'd5});
    chk("t2_credit2", credit, 2);
    cyc();
    chk("t2_chg2", {change_valid, change_coin}, {1'b1, 3'd2});
    chk("t2_idle_busy", busy, 0);
    cyc();
    chk("t2_chg_end", {change_valid, change_coin}, 0);

    // illegal coin, overflow reject, exact max
    coin(3'd3);
    chk("t3_illegal_rej", reject, 1);
    chk("t3_illegal_cr", credit, 0);
    for (int i = 0; i < 9; i++) coin(3'd5);
    coin(3'd2); coin(3'd1);
    chk("t3_credit48", credit, 48);
    coin(3'd5);
    chk("t3_over_rej", reject, 1);
    chk("t3_over_cr", credit, 48);
    coin(3'd2);
    chk("t3_max_rej", reject, 0);
    chk("t3_credit50", credit, 50);
    do_cancel();
    drain("t3_drain", 50);

    // cancel at zero credit does nothing
    do_cancel();
    chk("idle_cancel", {busy, change_valid}, 0);

    // insufficient credit, then refund
    coin(3'd5);
    sel(2'd2);
    chk("t4_insuff", insuff, 1);
    chk("t4_novend", vend_valid, 0);
    chk("t4_credit", credit, 5);
    cyc();
    chk("t4_insuff_pulse", insuff, 0);
    do_cancel();
    chk("t4_busy", busy, 1);
    cyc();
    chk("t4_chg5", {change_valid, change_coin}, {1'b1, 3'd5});
    chk("t4_idle", {busy, 8'(credit)}, 0);

    // cancel + sel + coin together at credit 4
    coin(3'd2); coin(3'd2);
    chk("t5_credit4", credit, 4);
    cancel = 1; sel_valid = 1; sel_id = 2'd0; coin_valid = 1; coin_val = 3'd1;
    cyc();
    cancel = 0; sel_valid = 0; coin_valid = 0; coin_val = 0;
    chk("t5_reject", reject, 1);
    chk("t5_novend", {vend_valid, insuff}, 0);
    chk("t5_credit", credit, 4);
    cyc();
    chk("t5_chg2a", {change_valid, change_coin}, {1'b1, 3'd2});
    cyc();
    chk("t5_chg2b", {change_valid, change_coin}, {1'b1, 3'd2});
    chk("t5_idle", {busy, 8'(credit)}, 0);

    // free product at zero credit
    sel(2'd3);
    chk("t6_free_vend", {vend_valid, 2'(vend_id)}, 3'b111);
    chk("t6_credit", credit, 0);
    cyc();
    chk("t6_after", {busy, change_valid}, 0);

    // reset while 7 units of change are pending
    coin(3'd5); coin(3'd2);
    do_cancel();
    chk("t7_pending", {busy, 8'(credit)}, {1'b1, 8'd7});
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("t7_rst_credit", credit, 0);
    chk("t7_rst_outs", {change_valid, change_coin, busy}, 0);
    cyc();
    chk("t7_forfeit", {change_valid, busy, 8'(credit)}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
